mem_responder: RTL and testbench

- Memory-side responder for the core's instruction/data memory request/response interface.
- Accepts one request at a time (read or write, byte/half/word with sign/zero extension) and returns a response after a parameterised latency on res_valid.
- Backed by an internal word-addressed RAM; one instance serves imem, another dmem.
- Core holds a request stable and stalls until res_valid.

---
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM behind a single-outstanding request/response
// port. Each accepted request produces exactly one res_valid pulse LATENCY
// cycles after acceptance. The pulse carries read data, which is sign- or
// zero-extended from byte/half/word, or an error flag.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid             request present; held stable until res_valid
//   req_addr[31:0]        byte address (wraps modulo DEPTH*4)
//   req_data[31:0]        store data, right-aligned
//   req_fcn               0 = read, 1 = write
//   req_typ[2:0]          1=B 2=H 3=W 5=BU 6=HU 7=WU
//   res_valid             one-cycle response pulse
//   res_data[31:0]        read data; 0 for writes, errors and idle cycles
//   res_err               misaligned address or illegal typ
module mem_responder #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_fcn,
  input  logic [2:0]  req_typ,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;
  localparam logic [2:0] MT_WU = 3'd7;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic           accept;

  // Latched request; only the address bits that select a word and lane are kept.
  logic [AW+1:0]  addr_q;
  logic [31:0]    data_q;
  logic           fcn_q;
  logic [2:0]     typ_q;

  logic [31:0]    mem [DEPTH];

  logic           is_b, is_h, is_w, is_sgn, err;
  logic [1:0]     lane;
  logic [AW-1:0]  idx;
  logic [31:0]    rword, rdata, wdata;
  logic [15:0]    rsh;
  logic [3:0]     wmask;
  logic           do_write;

  // Decode of the latched request.
  always_comb begin
    is_b   = (typ_q == MT_B) || (typ_q == MT_BU);
    is_h   = (typ_q == MT_H) || (typ_q == MT_HU);
    is_w   = (typ_q == MT_W) || (typ_q == MT_WU);
    is_sgn = (typ_q == MT_B) || (typ_q == MT_H);
    lane   = addr_q[1:0];
    idx    = addr_q[AW+1:2];
    err    = !(is_b || is_h || is_w) || (is_h && addr_q[0]) || (is_w && (addr_q[1:0] != 2'd0));
  end

  // Read path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rword = mem[idx];
    rsh   = 16'(rword >> {lane, 3'b000});
    rdata = rword;
    if (is_b)      rdata = is_sgn ? {{24{rsh[7]}},  rsh[7:0]} : {24'd0, rsh[7:0]};
    else if (is_h) rdata = is_sgn ? {{16{rsh[15]}}, rsh}      : {16'd0, rsh};
  end

  // Write path: store data replicated across lanes, the mask picks the target.
  always_comb begin
    wmask = 4'hf;
    wdata = data_q;
    if (is_b) begin
      wmask = 4'b0001 << lane;
      wdata = {4{data_q[7:0]}};
    end else if (is_h) begin
      wmask = 4'b0011 << lane;
      wdata = {2{data_q[15:0]}};
    end
  end

  // A reset arriving during RESP suppresses both the commit and the pulse.
  assign do_write = (state == RESP) && fcn_q && !err && !reset;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    res_valid = 1'b0;
    res_data  = 32'd0;
    res_err   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        if (!reset) begin
          res_valid = 1'b1;
          res_err   = err;
          res_data  = (err || fcn_q) ? 32'd0 : rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      data_q <= 32'd0;
      fcn_q  <= 1'b0;
      typ_q  <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= req_addr[AW+1:0];
        data_q <= req_data;
        fcn_q  <= req_fcn;
        typ_q  <= req_typ;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with LATENCY 1, 3 and 4 share the
// request bus, and each has its own req_valid. A byte-lane memory model per
// instance predicts read data, errors and latency.
module tb_mem_responder;

  localparam int DEPTH = 4096;
  localparam int LAT [3] = '{1, 3, 4};

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [31:0] req_addr, req_data;
  logic        req_fcn;
  logic [2:0]  req_typ;
  logic [2:0]  rv;
  logic [31:0] rdat [3];
  logic [2:0]  rerr;

  int n_chk  = 0;
  int n_pass = 0;

  bit [31:0] mdl [3][DEPTH];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_addr(req_addr),
    .req_data(req_data), .req_fcn(req_fcn), .req_typ(req_typ),
    .res_valid(rv[0]), .res_data(rdat[0]), .res_err(rerr[0]));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_addr(req_addr),
    .req_data(req_data), .req_fcn(req_fcn), .req_typ(req_typ),
    .res_valid(rv[1]), .res_data(rdat[1]), .res_err(rerr[1]));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_addr(req_addr),
    .req_data(req_data), .req_fcn(req_fcn), .req_typ(req_typ),
    .res_valid(rv[2]), .res_data(rdat[2]), .res_err(rerr[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: typ gives a size (0 = illegal). Alignment means the lane is a
  // multiple of the size. Writes patch size bytes at the lane. Reads shift the
  // lane down, mask to the size and optionally sign-fill.
  function automatic void model(input int k, input bit fcn, input bit [2:0] typ,
                                input bit [31:0] addr, input bit [31:0] data,
                                output bit [31:0] rd, output bit err);
    int sz; bit sgn; int lane; int idx; bit [31:0] w, v, mask;
    sgn = 1'b0;
    case (typ)
      3'd1: begin sz = 1; sgn = 1'b1; end
      3'd2: begin sz = 2; sgn = 1'b1; end
      3'd3: sz = 4;
      3'd5: sz = 1;
      3'd6: sz = 2;
      3'd7: sz = 4;
      default: sz = 0;
    endcase
    lane = int'(addr % 4);
    idx  = int'((addr / 4) % DEPTH);
    err  = (sz == 0) ? 1'b1 : ((lane % sz) != 0);
    rd   = 32'd0;
    if (err) return;
    w = mdl[k][idx];
    if (fcn) begin
      if (sz == 1)      w[8*lane +: 8]  = data[7:0];
      else if (sz == 2) w[8*lane +: 16] = data[15:0];
      else              w = data;
      mdl[k][idx] = w;
    end else if (sz == 4) begin
      rd = w;
    end else begin
      v    = w >> (8 * lane);
      mask = (sz == 1) ? 32'h0000_00ff : 32'h0000_ffff;
      rd   = v & mask;
      if (sgn && v[8*sz-1]) rd = rd | ~mask;
    end
  endfunction

  // Called at a negedge with instance k idle; returns at a negedge with k idle.
  task automatic do_req(input int k, input bit fcn, input bit [2:0] typ,
                        input bit [31:0] addr, input bit [31:0] data, input string tag);
    bit [31:0] er; bit ee; int n;
    model(k, fcn, typ, addr, data, er, ee);
    req_addr = addr; req_data = data; req_fcn = fcn; req_typ = typ;
    req_valid[k] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!rv[k]) chk({tag, "_idle0"}, rdat[k] | 32'(rerr[k]), 32'd0);
    end while (!rv[k] && n < 40);
    req_valid[k] = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(LAT[k]));
    chk({tag, "_data"}, rdat[k], er);
    chk({tag, "_err"}, 32'(rerr[k]), 32'(ee));
    @(negedge clk);
    chk({tag, "_pulse1"}, 32'(rv[k]), 32'd0);
  endtask

  initial begin
    bit [31:0] er; bit ee; bit [31:0] a;
    reset = 1'b1; req_valid = 3'b000;
    req_addr = 32'd0; req_data = 32'd0; req_fcn = 1'b0; req_typ = 3'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_vld", 32'(rv[k]), 32'd0);
      chk("rst_data", rdat[k], 32'd0);
      chk("rst_err", 32'(rerr[k]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Fill the first 256 words of every instance so reads are well defined.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 256; i++) do_req(k, 1'b1, 3'd3, 32'(i * 4), $urandom, "init");

    // Word and sub-word lanes, LATENCY=1.
    do_req(0, 1'b1, 3'd3, 32'h100, 32'hDEADBEEF, "sw");
    do_req(0, 1'b0, 3'd3, 32'h100, 32'h0, "lw");
    chk("lw_const", mdl[0][64], 32'hDEADBEEF);
    do_req(0, 1'b1, 3'd3, 32'h100, 32'h0, "sw0");
    do_req(0, 1'b1, 3'd1, 32'h103, 32'h80, "sb");
    do_req(0, 1'b0, 3'd1, 32'h103, 32'h0, "lb");
    do_req(0, 1'b0, 3'd5, 32'h103, 32'h0, "lbu");
    do_req(0, 1'b0, 3'd3, 32'h100, 32'h0, "lw_b");
    do_req(0, 1'b1, 3'd2, 32'h102, 32'h1234, "sh");
    do_req(0, 1'b0, 3'd3, 32'h100, 32'h0, "lw_h");
    do_req(0, 1'b0, 3'd2, 32'h102, 32'h0, "lh");
    // Misalignment and illegal typ.
    do_req(0, 1'b0, 3'd3, 32'h101, 32'h0, "lw_mis");
    do_req(0, 1'b1, 3'd3, 32'h101, 32'hFFFFFFFF, "sw_mis");
    do_req(0, 1'b0, 3'd3, 32'h100, 32'h0, "lw_unch");
    do_req(0, 1'b0, 3'd2, 32'h103, 32'h0, "lh_mis");
    do_req(0, 1'b0, 3'd4, 32'h100, 32'h0, "typ4");
    do_req(0, 1'b1, 3'd0, 32'h100, 32'h55, "typ0_wr");
    do_req(0, 1'b0, 3'd3, 32'h100, 32'h0, "lw_unch2");
    // Address wrap.
    do_req(0, 1'b1, 3'd3, 32'h4000, 32'hA5A5A5A5, "sw_wrap");
    do_req(0, 1'b0, 3'd3, 32'h0000, 32'h0, "lw_wrap");

    // Throughput with req_valid held high, LATENCY=3.
    model(1, 1'b0, 3'd3, 32'h100, 32'h0, er, ee);
    req_addr = 32'h100; req_fcn = 1'b0; req_typ = 3'd3;
    req_valid[1] = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk); @(negedge clk);
      chk("thr_vld", 32'(rv[1]), 32'((n == 3) || (n == 7) || (n == 11)));
      if (rv[1]) chk("thr_data", rdat[1], er);
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("thr_end", 32'(rv[1]), 32'd0);

    // Reset during WAIT, LATENCY=4: the store is dropped.
    req_addr = 32'h20; req_data = 32'h11223344; req_fcn = 1'b1; req_typ = 3'd3;
    req_valid[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid[2] = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rwait_vld", 32'(rv[2]), 32'd0);
    chk("rwait_data", rdat[2], 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); @(negedge clk);
      chk("rwait_after", 32'(rv[2]) | rdat[2] | 32'(rerr[2]), 32'd0);
    end
    do_req(2, 1'b0, 3'd3, 32'h20, 32'h0, "rwait_lw");

    // Reset during RESP, LATENCY=1: no pulse and no commit.
    req_addr = 32'h24; req_data = 32'hCAFEF00D; req_fcn = 1'b1; req_typ = 3'd3;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rresp_vld", 32'(rv[0]), 32'd0);
    chk("rresp_data", rdat[0], 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    do_req(0, 1'b0, 3'd3, 32'h24, 32'h0, "rresp_lw");

    // Random traffic over the filled region, including wrap aliases.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 150; i++) begin
        a = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
        a = a | (32'($urandom_range(0, 3)) << 14);
        do_req(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rnd");
      end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
